// File: rtl/acc_ctrl_if.sv
// acc_ctrl_if: bundles the job configuration, operand stream qualifier and
// PE control/status outputs of the accumulation controller.
//
// Parameters:
//   CNT_W - width of acc_len_i (beats per accumulation window)
//   WIN_W - width of n_win_i (windows per job)
//
// Signals:
//   start_i        job start request, honoured only while idle
//   acc_len_i      beats per accumulation window
//   n_win_i        windows in the job
//   vec_mode_i     00 = 32-bit, 01 = 8-bit, 10 = 16-bit, 11 = as 00
//   stream_valid_i valid beat on the PE operand stream
//   acc_match_o    combinational match to PE acc_match_i
//   acc_sel_o      accumulation-select bit (mirrors busy_o)
//   out_valid_o    PE result register holds a completed accumulation
//   last_o         marks the final out_valid_o of a job
//   busy_o         job in progress
//   done_o         one-cycle job-complete pulse
//   err_o          sticky configuration/protocol error
//
// Modports:
//   slave  - the controller side (acc_ctrl)
//   master - the side that issues jobs and drives the stream qualifier
interface acc_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start_i;
  logic [CNT_W-1:0] acc_len_i;
  logic [WIN_W-1:0] n_win_i;
  logic [1:0]       vec_mode_i;
  logic             stream_valid_i;
  logic             acc_match_o;
  logic             acc_sel_o;
  logic             out_valid_o;
  logic             last_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport slave (
    input  start_i, acc_len_i, n_win_i, vec_mode_i, stream_valid_i,
    output acc_match_o, acc_sel_o, out_valid_o, last_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, acc_len_i, n_win_i, vec_mode_i, stream_valid_i,
    input  acc_match_o, acc_sel_o, out_valid_o, last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/acc_ctrl.sv
// acc_ctrl: accumulation controller for the PEA accumulation PEs.
//
// Counts valid stream beats into fixed-length windows, pulses acc_match on
// the first beat of every window plus one flush pulse after the last window,
// and delays the resulting result strobe to line up with the PE output
// register for the configured vector mode (latency 1/3/4 for 32/16/8-bit).
//
// Parameters:
//   CNT_W - beat counter / acc_len width
//   WIN_W - window counter / n_win width
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous reset, active-high
//   bus    - acc_ctrl_if.slave (config, stream qualifier, PE control/status)
//
// Build option:
//   ACC_CTRL_ERR_CHECK_EN - when defined, err_o latches on a zero-length or
//   zero-window start, a start while busy, or a stream beat during FLUSH.
//   When undefined err_o is tied low and those cases are simply ignored.
module acc_ctrl #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  acc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] acc_len;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] n_win;
  logic [1:0]       vec_mode;
  logic             first;
  logic             busy;
  logic             done;

  logic [2:0]       val_sr;
  logic [2:0]       last_sr;
  logic             out_valid;
  logic             last;

  logic             acc_match;
  logic             res_pulse;
  logic             flush_now;

  // The PE consumes acc_match in the same cycle, so it is decoded straight
  // from the stream qualifier. The first match of a job only discards the
  // PE feedback value, hence no result strobe for it.
  always_comb begin
    flush_now = (state == FLUSH);
    acc_match = flush_now ||
                ((state == ACC) && bus.stream_valid_i && (beat_cnt == '0));
    res_pulse = acc_match && !first;
  end

  // Job sequencing: window/beat counting in ACC, a single flush cycle, then
  // wait for the final result strobe before reporting done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      win_cnt  <= '0;
      acc_len  <= '0;
      n_win    <= '0;
      vec_mode <= 2'b00;
      first    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && (bus.acc_len_i != '0) && (bus.n_win_i != '0)) begin
            acc_len  <= bus.acc_len_i;
            n_win    <= bus.n_win_i;
            vec_mode <= bus.vec_mode_i;
            beat_cnt <= '0;
            win_cnt  <= '0;
            first    <= 1'b1;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end
        ACC: begin
          if (bus.stream_valid_i) begin
            if (beat_cnt == '0) begin
              first <= 1'b0;
            end
            if (beat_cnt == acc_len - CNT_W'(1)) begin
              beat_cnt <= '0;
              win_cnt  <= win_cnt + WIN_W'(1);
              if (win_cnt == n_win - WIN_W'(1)) begin
                state <= FLUSH;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          state <= DRAIN;
        end
        DRAIN: begin
          // out_valid/last are registered, so done lands one cycle later.
          if (out_valid && last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result-strobe delay line. The tap feeding the output flop selects the
  // latency, so out_valid/last are always driven straight from a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_sr    <= 3'b000;
      last_sr   <= 3'b000;
      out_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      val_sr  <= {val_sr[1:0], res_pulse};
      last_sr <= {last_sr[1:0], res_pulse && flush_now};
      case (vec_mode)
        2'b01: begin
          out_valid <= val_sr[2];
          last      <= last_sr[2];
        end
        2'b10: begin
          out_valid <= val_sr[1];
          last      <= last_sr[1];
        end
        default: begin
          out_valid <= res_pulse;
          last      <= res_pulse && flush_now;
        end
      endcase
    end
  end

`ifdef ACC_CTRL_ERR_CHECK_EN
  logic err;

  // Sticky error flag for bad configurations and protocol violations.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if ((state == IDLE && bus.start_i &&
                  ((bus.acc_len_i == '0) || (bus.n_win_i == '0))) ||
                 (state != IDLE && bus.start_i) ||
                 (state == FLUSH && bus.stream_valid_i)) begin
      err <= 1'b1;
    end
  end

  assign bus.err_o = err;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.acc_match_o = acc_match;
  assign bus.acc_sel_o   = busy;
  assign bus.busy_o      = busy;
  assign bus.out_valid_o = out_valid;
  assign bus.last_o      = last;
  assign bus.done_o      = done;

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: scoreboard bench for acc_ctrl.
//
// The stimulus side issues jobs (directed cases plus random jobs with random
// beat gaps) and, from the window arithmetic of each job, pushes the cycles
// at which matches, result strobes and done must appear. A monitor on the
// falling edge pops and compares whenever the DUT presents one of those
// outputs. Honours ACC_CTRL_ERR_CHECK_EN for the error-flag expectations.
module tb_acc_ctrl;

  logic clk;
  logic rst;
  int   cyc;

  int   vec_count;
  int   miss_count;
  bit   sb_enable;
  int   busy_from;
  int   busy_to;

  int   match_q[$];
  int   ov_cyc_q[$];
  int   ov_last_q[$];
  int   done_q[$];

`ifdef ACC_CTRL_ERR_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  acc_ctrl_if #(.CNT_W(16), .WIN_W(16)) bus ();

  acc_ctrl #(.CNT_W(16), .WIN_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock and cycle counter used to timestamp expectations.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count = vec_count + 1;
    if (actual != expected) begin
      miss_count = miss_count + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event, and
  // checks busy/acc_sel against the job window the stimulus side recorded.
  always @(negedge clk) begin
    if (sb_enable) begin
      if (bus.acc_match_o) begin
        if (match_q.size() == 0) checkOutput("unexpected acc_match", cyc, -1);
        else checkOutput("acc_match cycle", cyc, match_q.pop_front());
      end
      if (bus.out_valid_o) begin
        if (ov_cyc_q.size() == 0) checkOutput("unexpected out_valid", cyc, -1);
        else begin
          checkOutput("out_valid cycle", cyc, ov_cyc_q.pop_front());
          checkOutput("last_o", int'(bus.last_o), ov_last_q.pop_front());
        end
      end else begin
        checkOutput("last without out_valid", int'(bus.last_o), 0);
      end
      if (bus.done_o) begin
        if (done_q.size() == 0) checkOutput("unexpected done", cyc, -1);
        else checkOutput("done cycle", cyc, done_q.pop_front());
      end
      checkOutput("busy_o", int'(bus.busy_o), int'(cyc >= busy_from && cyc < busy_to));
      checkOutput("acc_sel_o", int'(bus.acc_sel_o), int'(cyc >= busy_from && cyc < busy_to));
      checkOutput("err_o during job", int'(bus.err_o), 0);
    end
  end

  task automatic checkQueues;
    checkOutput("pending matches", match_q.size(), 0);
    checkOutput("pending out_valid", ov_cyc_q.size(), 0);
    checkOutput("pending done", done_q.size(), 0);
    match_q.delete();
    ov_cyc_q.delete();
    ov_last_q.delete();
    done_q.delete();
  endtask

  // Issues one job. Beat k of the job (counting valid beats only) opens a
  // window when k is a multiple of len; every window open after the first
  // delivers the previous window's result L cycles later, and the flush one
  // cycle after the last beat delivers the final one.
  task automatic applyStimulus(input int len, input int nwin, input int mode,
                               input bit use_pat, input logic [31:0] pat, input int pct);
    int lat;
    int beats;
    int total;
    int off;
    int fc;
    bit v;
    lat   = (mode == 1) ? 4 : (mode == 2) ? 3 : 1;
    total = len * nwin;
    beats = 0;
    off   = 0;
    fc    = 0;
    stepCycle;
    bus.start_i        = 1'b1;
    bus.acc_len_i      = 16'(len);
    bus.n_win_i        = 16'(nwin);
    bus.vec_mode_i     = 2'(mode);
    bus.stream_valid_i = 1'b0;
    busy_from = cyc + 1;
    busy_to   = 32'h7fffffff;
    while (beats < total) begin
      stepCycle;
      bus.start_i   = 1'b0;
      bus.acc_len_i = 16'($urandom);
      bus.n_win_i   = 16'($urandom);
      if (use_pat) v = (off < 32) ? pat[off] : 1'b1;
      else v = ($urandom_range(99) < pct);
      bus.stream_valid_i = v;
      if (v) begin
        if (beats % len == 0) begin
          match_q.push_back(cyc);
          if (beats != 0) begin
            ov_cyc_q.push_back(cyc + lat);
            ov_last_q.push_back(0);
          end
        end
        beats = beats + 1;
        if (beats == total) begin
          fc = cyc + 1;
          match_q.push_back(fc);
          ov_cyc_q.push_back(fc + lat);
          ov_last_q.push_back(1);
          done_q.push_back(fc + lat + 1);
          busy_to = fc + lat + 1;
        end
      end
      off = off + 1;
    end
    stepCycle;
    bus.stream_valid_i = 1'b0;
    for (int i = 0; i <= lat; i++) begin
      stepCycle;
      bus.stream_valid_i = 1'($urandom_range(1));
    end
    stepCycle;
    bus.stream_valid_i = 1'b0;
    checkQueues();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " acc_match_o"}, int'(bus.acc_match_o), 0);
    checkOutput({tag, " acc_sel_o"}, int'(bus.acc_sel_o), 0);
    checkOutput({tag, " out_valid_o"}, int'(bus.out_valid_o), 0);
    checkOutput({tag, " last_o"}, int'(bus.last_o), 0);
    checkOutput({tag, " busy_o"}, int'(bus.busy_o), 0);
    checkOutput({tag, " done_o"}, int'(bus.done_o), 0);
    checkOutput({tag, " err_o"}, int'(bus.err_o), 0);
  endtask

  initial begin
    cyc        = 0;
    vec_count  = 0;
    miss_count = 0;
    sb_enable  = 1'b0;
    busy_from  = 0;
    busy_to    = 0;
    rst        = 1'b1;
    bus.start_i        = 1'b0;
    bus.acc_len_i      = '0;
    bus.n_win_i        = '0;
    bus.vec_mode_i     = 2'b00;
    bus.stream_valid_i = 1'b0;

    repeat (3) stepCycle;
    rst = 1'b0;
    checkAllZero("reset");
    sb_enable = 1'b1;

    // Directed cases: 32-bit, 8-bit, gapped stream, unit windows, 16-bit.
    applyStimulus(4, 2, 0, 1'b0, 32'h0, 100);
    applyStimulus(4, 2, 1, 1'b0, 32'h0, 100);
    applyStimulus(3, 1, 0, 1'b1, 32'b100101, 100);
    applyStimulus(1, 3, 0, 1'b0, 32'h0, 100);
    applyStimulus(2, 3, 2, 1'b0, 32'h0, 100);
    applyStimulus(3, 2, 3, 1'b0, 32'h0, 100);

    // Random jobs with random beat gaps.
    for (int j = 0; j < 25; j++) begin
      applyStimulus(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)),
                    int'($urandom_range(3, 0)), 1'b0, 32'h0,
                    int'($urandom_range(100, 40)));
    end

    // Reset mid-job with an 8-bit result still in the delay line.
    sb_enable = 1'b0;
    stepCycle;
    bus.start_i    = 1'b1;
    bus.acc_len_i  = 16'd4;
    bus.n_win_i    = 16'd3;
    bus.vec_mode_i = 2'b01;
    for (int i = 0; i < 6; i++) begin
      stepCycle;
      bus.start_i        = 1'b0;
      bus.stream_valid_i = 1'b1;
    end
    checkOutput("busy before reset", int'(bus.busy_o), 1);
    stepCycle;
    rst = 1'b1;
    stepCycle;
    rst = 1'b0;
    checkAllZero("after mid-job reset");
    for (int i = 0; i < 8; i++) begin
      stepCycle;
      checkOutput("post-reset out_valid", int'(bus.out_valid_o), 0);
      checkOutput("post-reset done", int'(bus.done_o), 0);
      checkOutput("post-reset acc_match", int'(bus.acc_match_o), 0);
      checkOutput("post-reset busy", int'(bus.busy_o), 0);
    end
    bus.stream_valid_i = 1'b0;
    busy_from = 0;
    busy_to   = 0;
    sb_enable = 1'b1;
    applyStimulus(2, 2, 0, 1'b0, 32'h0, 70);

    // Zero-length and zero-window starts.
    sb_enable = 1'b0;
    stepCycle;
    bus.start_i   = 1'b1;
    bus.acc_len_i = 16'd0;
    bus.n_win_i   = 16'd2;
    stepCycle;
    bus.start_i = 1'b0;
    checkOutput("zero len busy", int'(bus.busy_o), 0);
    checkOutput("zero len err", int'(bus.err_o), ERR_EXP);
    repeat (3) stepCycle;
    checkOutput("err sticky", int'(bus.err_o), ERR_EXP);
    bus.start_i   = 1'b1;
    bus.acc_len_i = 16'd3;
    bus.n_win_i   = 16'd0;
    stepCycle;
    bus.start_i = 1'b0;
    checkOutput("zero win busy", int'(bus.busy_o), 0);
    checkOutput("zero win err", int'(bus.err_o), ERR_EXP);
    rst = 1'b1;
    stepCycle;
    rst = 1'b0;
    checkOutput("err cleared by reset", int'(bus.err_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
